regfile_sb: RTL
===============

# regfile_sb

Parametrised general-purpose register file with per-register pending (scoreboard) bits and a hardware clear sequencer. It sits in the decode/writeback boundary of the core. It serves two combinational operand reads and one writeback port. Issue logic marks destinations pending, and writeback clears them. A software-triggered sweep zeroes the whole file one entry per cycle without a global reset.

## Interface

Parameters:
- XLEN, 64, data width in bits
- NREGS, 32, number of architectural registers; power of two, at least 2
- AW, 5, address width; must equal log2(NREGS)
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never pending

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset; asynchronous, active-low
- rd_addr1, rd_addr2  input  AW  operand read addresses
- rd_data1, rd_data2  output  XLEN  operand read data, combinational
- rd_busy1, rd_busy2  output  1  pending bit of the addressed register, combinational
- wr_en  input  1  writeback strobe
- wr_addr  input  AW  writeback address
- wr_data  input  XLEN  writeback data
- iss_en  input  1  issue strobe; marks iss_addr pending
- iss_addr  input  AW  destination being issued
- clr_req  input  1  single-cycle request to start a clear sweep
- clr_busy  output  1  high while a sweep is in progress

## Operation

- **Storage:** NREGS x XLEN data array and an NREGS-bit busy vector.
- **Reads:**
  - rd_dataN returns the stored value of rd_addrN.
  - rd_busyN returns the busy bit of rd_addrN.
  - Address 0 returns data 0 and busy 0 when ZERO_REG=1.
- **Writeback:** when wr_en is high in state IDLE, the rising edge stores wr_data at wr_addr and clears busy[wr_addr].
- **Issue:** when iss_en is high in state IDLE, the rising edge sets busy[iss_addr].
- **Same-address issue and writeback in one cycle:** the data is written and busy ends **set**. The issue belongs to a younger instruction and wins.
- **Register 0 with ZERO_REG=1:** writes and issues to address 0 have no effect.
- **Clear FSM states:**
  - IDLE: clr_busy=0, index=0.
  - SWEEP: clr_busy=1.
- **Clear FSM transitions:**
  - IDLE to SWEEP on clr_req.
  - In SWEEP, each edge zeroes data[index] and busy[index], then increments index.
  - SWEEP to IDLE on the edge that clears index NREGS-1; index returns to 0.
- **During SWEEP:**
  - wr_en, iss_en and clr_req are ignored.
  - Reads continue and may return partially cleared contents.
- **Reset:** asserting rst_n low forces all data to 0, all busy bits to 0, state IDLE and index 0, including in the middle of a sweep.

## Timing

- Read latency is 0 cycles (combinational from address and state).
- Write and issue effects are visible on the read ports in the cycle after the edge that commits them, unless bypass is compiled in (see Configuration).
- A sweep occupies exactly NREGS cycles:
  - clr_busy rises in the cycle after the clr_req edge.
  - clr_busy falls after NREGS edges.
  - The next clr_req is accepted in the first IDLE cycle.
- Index arithmetic is AW bits wide and must not wrap inside a sweep. Termination is by compare with NREGS-1.
- Reset values of outputs:
  - rd_data*: 0 for any address.
  - rd_busy*: 0.
  - clr_busy: 0.

## Configuration

- REGFILE_BYPASS_EN defined: write-to-read forwarding is compiled in. When wr_en is high, state is IDLE, wr_addr equals rd_addrN, and that address is not a zero register, then in the same cycle:
  - rd_dataN = wr_data.
  - rd_busyN = 0, unless iss_en is also high with iss_addr equal to rd_addrN, in which case rd_busyN = 1.
- REGFILE_BYPASS_EN undefined: no forwarding. Read ports reflect only committed state, and a same-cycle write appears one cycle later.

## Test plan

- **Reset:** drive rst_n low mid-cycle after writing 0xDEAD to r5 and issuing r6 -> immediately rd_data(r5)=0, rd_busy(r6)=0, clr_busy=0.
- **Write/read and zero register:**
  - write r7=0x0123_4567_89AB_CDEF -> next cycle rd_data1(r7) equals that value.
  - write r0=0xFFFF with ZERO_REG=1 -> rd_data(r0)=0.
- **Scoreboard:**
  - issue r3 -> rd_busy(r3)=1 next cycle.
  - writeback r3=0x42 -> busy 0.
  - same-cycle issue and writeback to r3 -> data 0x42, busy 1.
- **Bypass:** with REGFILE_BYPASS_EN, wr r9=0xABC while rd_addr2=r9 -> same cycle rd_data2=0xABC, rd_busy2=0. Without the macro -> old value in that cycle, 0xABC the next cycle.
- **Sweep:** fill all registers with nonzero values and set busy on r1..r4, pulse clr_req -> clr_busy high for exactly 32 cycles, writes and issues ignored meanwhile, then all data=0 and all busy=0.
- **Reset mid-sweep:** assert rst_n low at sweep cycle 10 -> clr_busy=0 and all registers 0. After release, a new clr_req runs the full 32 cycles.

Source files
------------

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with scoreboard bits and clear sweep (optional REGFILE_BYPASS_EN forwarding)
module regfile_sb #(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rd_addr1,
    input  logic [AW-1:0]   rd_addr2,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2,
    output logic            rd_busy1,
    output logic            rd_busy2,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    input  logic            clr_req,
    output logic            clr_busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    logic [XLEN-1:0]  data_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    state_t           state_q;
    state_t           state_d;
    logic [AW-1:0]    idx_q;
    logic [AW-1:0]    idx_d;
    logic             idle;
    logic             wr_ok;
    logic             iss_ok;

    // Register 0 is hardwired only when ZERO_REG is set.
    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Writeback and issue only take effect while idle and off the zero register.
    assign wr_ok  = wr_en  && idle && !is_zero(wr_addr);
    assign iss_ok = iss_en && idle && !is_zero(iss_addr);

    // Clear sequencer state and sweep index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Sweep advances one entry per edge and ends by compare, so the index never wraps.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (clr_req) begin
                    state_d = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Sequencer outputs decoded from the current state.
    always_comb begin
        clr_busy = 1'b0;
        idle     = 1'b1;
        if (state_q == S_SWEEP) begin
            clr_busy = 1'b1;
            idle     = 1'b0;
        end
    end

    // Scoreboard next state; issue is applied after writeback so the younger issue wins.
    always_comb begin
        busy_d = busy_q;
        if (state_q == S_SWEEP) begin
            busy_d[idx_q] = 1'b0;
        end else begin
            if (wr_ok) begin
                busy_d[wr_addr] = 1'b0;
            end
            if (iss_ok) begin
                busy_d[iss_addr] = 1'b1;
            end
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Data array: the sweep zeroes one entry per edge, otherwise writeback stores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                data_q[i] <= '0;
            end
        end else if (state_q == S_SWEEP) begin
            data_q[idx_q] <= '0;
        end else if (wr_ok) begin
            data_q[wr_addr] <= wr_data;
        end
    end

    // Operand port 1, optionally forwarding the same-cycle writeback.
    always_comb begin
        rd_data1 = is_zero(rd_addr1) ? '0 : data_q[rd_addr1];
        rd_busy1 = is_zero(rd_addr1) ? 1'b0 : busy_q[rd_addr1];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
            rd_busy1 = iss_ok && (iss_addr == rd_addr1);
        end
`endif
    end

    // Operand port 2, optionally forwarding the same-cycle writeback.
    always_comb begin
        rd_data2 = is_zero(rd_addr2) ? '0 : data_q[rd_addr2];
        rd_busy2 = is_zero(rd_addr2) ? 1'b0 : busy_q[rd_addr2];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
            rd_busy2 = iss_ok && (iss_addr == rd_addr2);
        end
`endif
    end

endmodule
